// File: rtl/fixp_pkg.sv
// Shared helpers for the fixed-point multiplier arbiter: word width,
// saturation limits and requester-id width.
package fixp_pkg;

  function automatic int word_w(input int iw, input int fw);
    return iw + fw;
  endfunction

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixp_mul_arbiter_if.sv
// Request/result bus between the requesters and the shared multiplier.
interface fixp_mul_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
);
  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high; ready never depends on a request whose valid is low, and the
  // producer keeps data stable while valid is high and ready is low.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [IDW-1:0]    out_id;

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/fixp_mul_pipe.sv
// LAT-stage signed fixed-point multiplier with valid/id sideband; every
// stage freezes while i_stall is high.
module fixp_mul_pipe
  import fixp_pkg::*;
#(
  parameter int W   = 16,
  parameter int FW  = 8,
  parameter int LAT = 2,
  parameter int SAT = 0,
  parameter int IDW = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_stall,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic [IDW-1:0]      i_id,
  output logic                o_valid,
  output logic [W-1:0]        o_data,
  output logic [IDW-1:0]      o_id
);

  localparam logic signed [2*W-1:0] SMAX = (2*W)'(sat_max(W));
  localparam logic signed [2*W-1:0] SMIN = (2*W)'(sat_min(W));

  logic [LAT-1:0] r_v;
  logic [IDW-1:0] r_id [LAT];
  logic [W-1:0]   r_out;

  // Floor shift back to Q IW.FW, then wrap or clamp to the W-bit range.
  function automatic logic [W-1:0] finish(input logic signed [2*W-1:0] p);
    logic signed [2*W-1:0] r;
    r = p >>> FW;
    if (SAT != 0 && r > SMAX)      return SMAX[W-1:0];
    else if (SAT != 0 && r < SMIN) return SMIN[W-1:0];
    else                           return r[W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int k = 0; k < LAT; k++) r_id[k] <= '0;
    end else if (!i_stall) begin
      r_v[0]  <= i_valid;
      r_id[0] <= i_id;
      for (int k = 1; k < LAT; k++) begin
        r_v[k]  <= r_v[k-1];
        r_id[k] <= r_id[k-1];
      end
    end
  end

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_out <= '0;
        else if (!i_stall) r_out <= finish(i_a * i_b);
      end
    end else begin : g_multi
      logic signed [W-1:0]   r_a;
      logic signed [W-1:0]   r_b;
      logic signed [2*W-1:0] w_last;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a   <= '0;
          r_b   <= '0;
          r_out <= '0;
        end else if (!i_stall) begin
          r_a   <= i_a;
          r_b   <= i_b;
          r_out <= finish(w_last);
        end
      end

      if (LAT == 2) begin : g_nomid
        assign w_last = r_a * r_b;
      end else begin : g_mid
        logic signed [2*W-1:0] r_p [LAT-2];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < LAT - 2; k++) r_p[k] <= '0;
          end else if (!i_stall) begin
            r_p[0] <= r_a * r_b;
            for (int k = 1; k < LAT - 2; k++) r_p[k] <= r_p[k-1];
          end
        end
        assign w_last = r_p[LAT-3];
      end
    end
  endgenerate

  assign o_valid = r_v[LAT-1];
  assign o_id    = r_id[LAT-1];
  assign o_data  = r_out;

endmodule

// File: rtl/fixp_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier between
// NREQ requesters; results carry the requester id and stall on backpressure.
module fixp_mul_arbiter
  import fixp_pkg::*;
#(
  parameter int IW   = 8,
  parameter int FW   = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int SAT  = 0
) (
  input logic               clk,
  input logic               rst_n,
  fixp_mul_arbiter_if.slave bus
);

  localparam int W   = word_w(IW, FW);
  localparam int IDW = id_width(NREQ);

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW-1:0]  w_idx;
  logic            w_gnt;
  logic            w_stall;
  logic            w_out_valid;
  logic [NREQ-1:0] w_ready;

  assign w_stall = w_out_valid & ~bus.out_ready;

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    int j;
    j        = 0;
    w_idx    = '0;
    w_ready  = '0;
    w_gnt    = 1'b0;
    w_gnt_id = '0;
    if (rst_n && !w_stall) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(r_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        w_idx = IDW'(j);
        if (!w_gnt && bus.req_valid[w_idx]) begin
          w_gnt          = 1'b1;
          w_gnt_id       = w_idx;
          w_ready[w_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (w_gnt) r_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
  end

  assign bus.req_ready = w_ready;
  assign bus.out_valid = w_out_valid;

  fixp_mul_pipe #(
    .W   (W),
    .FW  (FW),
    .LAT (LAT),
    .SAT (SAT),
    .IDW (IDW)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_stall (w_stall),
    .i_valid (w_gnt),
    .i_a     (bus.req_a[int'(w_gnt_id)*W +: W]),
    .i_b     (bus.req_b[int'(w_gnt_id)*W +: W]),
    .i_id    (w_gnt_id),
    .o_valid (w_out_valid),
    .o_data  (bus.out_data),
    .o_id    (bus.out_id)
  );

endmodule

// File: tb/tb_fixp_mul_arbiter.sv
// Bench for fixp_mul_arbiter: a wrap instance and a saturate instance share
// the same stimulus and are checked against a queue-based reference model.
module tb_fixp_mul_arbiter;
  import fixp_pkg::*;

  localparam int IW   = 8;
  localparam int FW   = 8;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int W    = IW + FW;
  localparam int IDW  = id_width(NREQ);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   dw;
    logic [W-1:0]   ds;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              out_ready;

  fixp_mul_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus_w ();
  fixp_mul_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus_s ();

  assign bus_w.req_valid = req_valid;
  assign bus_w.req_a     = req_a;
  assign bus_w.req_b     = req_b;
  assign bus_w.out_ready = out_ready;
  assign bus_s.req_valid = req_valid;
  assign bus_s.req_a     = req_a;
  assign bus_s.req_b     = req_b;
  assign bus_s.out_ready = out_ready;

  fixp_mul_arbiter #(.IW(IW), .FW(FW), .NREQ(NREQ), .LAT(LAT), .SAT(0))
    dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
  fixp_mul_arbiter #(.IW(IW), .FW(FW), .NREQ(NREQ), .LAT(LAT), .SAT(1))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic with plain 64-bit integers.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit sat);
    longint p, r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p >>> FW;
    if (sat && r > sat_max(W)) r = sat_max(W);
    if (sat && r < sat_min(W)) r = sat_min(W);
    return r[W-1:0];
  endfunction

  // ---------------- reference model + scoreboard ----------------
  bit             vq[$];
  exp_t           exp_q[$];
  logic [W-1:0]   acc_w_q[$];
  logic [W-1:0]   acc_s_q[$];
  logic [IDW-1:0] acc_id_q[$];
  int             m_ptr;
  bit             prev_stall;
  logic [W-1:0]   prev_dw, prev_ds;
  logic [IDW-1:0] prev_id;

  always @(negedge clk) begin
    bit              exp_valid, stall, gnt;
    int              gid, j;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    #2;
    if (!rst_n) begin
      check("rst_valid", {bus_w.out_valid, bus_s.out_valid}, 0);
      check("rst_ready", {bus_w.req_ready, bus_s.req_ready}, 0);
      check("rst_data",  {bus_w.out_data, bus_s.out_data}, 0);
      check("rst_id",    {bus_w.out_id, bus_s.out_id}, 0);
      vq.delete();
      for (int k = 0; k < LAT; k++) vq.push_back(1'b0);
      exp_q.delete();
      m_ptr      = 0;
      prev_stall = 1'b0;
    end else begin
      exp_valid = vq[0];
      stall     = exp_valid && !out_ready;
      gnt       = 1'b0;
      gid       = 0;
      exp_rdy   = '0;
      if (!stall) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (!gnt && req_valid[j]) begin
            gnt        = 1'b1;
            gid        = j;
            exp_rdy[j] = 1'b1;
          end
        end
      end
      check("ready_w", bus_w.req_ready, exp_rdy);
      check("ready_s", bus_s.req_ready, exp_rdy);
      check("valid_w", bus_w.out_valid, exp_valid);
      check("valid_s", bus_s.out_valid, exp_valid);
      if (prev_stall) begin
        check("hold_w", {bus_w.out_id, bus_w.out_data}, {prev_id, prev_dw});
        check("hold_s", bus_s.out_data, prev_ds);
      end
      if (exp_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("data_w", bus_w.out_data, e.dw);
          check("data_s", bus_s.out_data, e.ds);
          check("id_w",   bus_w.out_id, e.id);
          check("id_s",   bus_s.out_id, e.id);
          acc_w_q.push_back(bus_w.out_data);
          acc_s_q.push_back(bus_s.out_data);
          acc_id_q.push_back(bus_w.out_id);
        end
      end
      prev_stall = stall;
      prev_dw    = bus_w.out_data;
      prev_ds    = bus_s.out_data;
      prev_id    = bus_w.out_id;
      if (!stall) begin
        void'(vq.pop_front());
        vq.push_back(gnt);
        if (gnt) begin
          e.id = IDW'(gid);
          e.dw = ref_mul(req_a[gid*W +: W], req_b[gid*W +: W], 1'b0);
          e.ds = ref_mul(req_a[gid*W +: W], req_b[gid*W +: W], 1'b1);
          exp_q.push_back(e);
          m_ptr = (gid + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = '0;
      out_ready = 1'b1;
    end
  endtask

  task automatic rand_operands();
    for (int p = 0; p < NREQ; p++) begin
      req_a[p*W +: W] = W'($urandom);
      req_b[p*W +: W] = W'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 1023));
    end
  endtask

  task automatic drive_all(input logic [NREQ-1:0] v, input int n, input bit rdy);
    repeat (n) begin
      @(negedge clk);
      req_valid = v;
      out_ready = rdy;
      rand_operands();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] t_a  [5] = '{16'h0180, 16'hFF00, 16'hFFFF, 16'h6400, 16'h9C00};
  logic [W-1:0] t_b  [5] = '{16'h0200, 16'h0080, 16'h0001, 16'h0400, 16'h0400};
  logic [W-1:0] t_ew [5] = '{16'h0300, 16'hFF80, 16'hFFFF, 16'h9000, 16'h7000};
  logic [W-1:0] t_es [5] = '{16'h0300, 16'hFF80, 16'hFFFF, 16'h7FFF, 16'h8000};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed arithmetic on port 0, back-to-back.
    acc_w_q.delete(); acc_s_q.delete(); acc_id_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      out_ready = 1'b1;
      req_a[0 +: W] = t_a[i];
      req_b[0 +: W] = t_b[i];
    end
    idle(LAT + 3);
    check("dir_count", acc_w_q.size(), 5);
    for (int i = 0; i < 5 && i < acc_w_q.size(); i++) begin
      check("dir_wrap", acc_w_q[i], t_ew[i]);
      check("dir_sat",  acc_s_q[i], t_es[i]);
      check("dir_id",   acc_id_q[i], 0);
    end

    // Reset with a full pipeline, then round-robin from port 0.
    drive_all(4'b1111, 3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acc_id_q.delete();
    req_valid = 4'b1111;
    rand_operands();
    drive_all(4'b1111, 11, 1'b1);
    drive_all(4'b1011, 9, 1'b1);
    idle(LAT + 3);
    check("rr_count", acc_id_q.size(), 21);
    for (int i = 0; i < 21 && i < acc_id_q.size(); i++) begin
      if (i < 12) check("rr_all", acc_id_q[i], i % 4);
      else        check("rr_drop", acc_id_q[i], (i % 3 == 2) ? 3 : i % 3);
    end

    // Backpressure with a full pipeline.
    drive_all(4'b1111, 4, 1'b1);
    drive_all(4'b1111, 3, 1'b0);
    drive_all(4'b1111, 4, 1'b1);
    idle(LAT + 3);
    check("bp_drain", exp_q.size(), 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rand_operands();
    end
    idle(LAT + 4);
    check("rand_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
